// File: rtl/vecshift_drain_if.sv
// Output stream of vecshift_drain: first-word-fall-through FIFO head with a
// valid/ready handshake. The drain drives the master side, the consumer the slave.
interface vecshift_drain_if #(
  parameter int REG_WIDTH = 8
);
  logic [REG_WIDTH-1:0] outData;
  logic                 outValid;
  logic                 outReady;
  logic                 outLast;

  modport master (
    output outData,
    output outValid,
    output outLast,
    input  outReady
  );

  modport slave (
    input  outData,
    input  outValid,
    input  outLast,
    output outReady
  );
endinterface

// File: rtl/vecshift_drain.sv
// vecshift_drain: drains a column of vecshift registers into a FWFT FIFO.
// A start request parallel-loads the column (ARM), captures every isData word from
// the column's output end (SHIFT) until an isLast word, then disables the column
// for one cycle (FLUSH). Define VECSHIFT_DRAIN_TIMEOUT_EN to add a watchdog that
// aborts a SHIFT phase lasting COL_LEN+2 cycles and raises a sticky timeoutErr.
// The VECREG_* encodings below mirror those of vecshift_reg.svh.
module vecshift_drain #(
  parameter int REG_WIDTH = -1,
  parameter int COL_LEN   = 8,
  localparam int VECREG_CONFIG_WIDTH = 2,
  localparam int VECREG_STATUS_WIDTH = 2,
  localparam int CNT_W = $clog2(COL_LEN + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic [VECREG_CONFIG_WIDTH-1:0] colConfSig,
  input  logic [REG_WIDTH-1:0]           colData,
  input  logic [VECREG_STATUS_WIDTH-1:0] colStatus,
  vecshift_drain_if.master               out,
  output logic [CNT_W-1:0]               wordCount,
  output logic                           timeoutErr
);

  localparam logic [VECREG_CONFIG_WIDTH-1:0] VECREG_IDLE        = 2'b00;
  localparam logic [VECREG_CONFIG_WIDTH-1:0] VECREG_PARALLEL_EN = 2'b01;
  localparam logic [VECREG_CONFIG_WIDTH-1:0] VECREG_DISABLE     = 2'b11;

  localparam int PTR_W = $clog2(COL_LEN);
  localparam int ENT_W = REG_WIDTH + 1;

  if (REG_WIDTH <= 0) begin : g_bad_width
    $error("vecshift_drain: REG_WIDTH must be > 0");
  end
  if (COL_LEN < 2) begin : g_bad_len
    $error("vecshift_drain: COL_LEN must be >= 2");
  end

  typedef enum logic [1:0] {StIdle, StArm, StShift, StFlush} state_e;

  state_e                         state_q, state_d;
  logic [VECREG_CONFIG_WIDTH-1:0] conf_q, conf_d;
  logic [CNT_W-1:0]               word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [ENT_W-1:0]               mem_q [COL_LEN];
  logic [ENT_W-1:0]               head;
  logic                           fifo_empty, fifo_full, pop, push_req, push;

`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
  localparam int WD_W = $clog2(COL_LEN + 3);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
`endif

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(COL_LEN));
  assign pop        = !fifo_empty && out.outReady;
  assign push_req   = (state_q == StShift) && colStatus[0];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);

  // FIFO pointer and occupancy next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(COL_LEN - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(COL_LEN - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Drain FSM next-state, word counter, watchdog and registered column config.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
    wdog_d     = wdog_q;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && fifo_empty) begin
          state_d    = StArm;
          word_cnt_d = '0;
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
        end
      end
      StArm: begin
        state_d = StShift;
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      StShift: begin
        if (push_req && colStatus[1]) begin
          state_d = StFlush;
        end
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
        // wdog_q holds completed SHIFT cycles; this is the (COL_LEN+2)-th one.
        else if (wdog_q == WD_W'(COL_LEN + 1)) begin
          state_d   = StFlush;
          timeout_d = 1'b1;
        end
        wdog_d = wdog_q + WD_W'(1);
`endif
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (push && (word_cnt_q != CNT_W'(COL_LEN))) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    // Config follows the state being entered so it is aligned with that state.
    conf_d = VECREG_IDLE;
    if (state_d == StArm) begin
      conf_d = VECREG_PARALLEL_EN;
    end else if (state_d == StFlush) begin
      conf_d = VECREG_DISABLE;
    end
  end

  // Control state with synchronous reset; reset holds the column disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      conf_q     <= VECREG_DISABLE;
      word_cnt_q <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      conf_q     <= conf_d;
      word_cnt_q <= word_cnt_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {colStatus[1], colData};
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign out.outData  = head[REG_WIDTH-1:0];
  assign out.outValid = !fifo_empty;
  assign out.outLast  = !fifo_empty && head[REG_WIDTH];
  assign busy         = (state_q != StIdle);
  assign colConfSig   = conf_q;
  assign wordCount    = word_cnt_q;
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
  assign timeoutErr   = timeout_q;
`else
  assign timeoutErr   = 1'b0;
`endif

endmodule

// File: tb/tb_vecshift_drain.sv
// Bench for vecshift_drain (COL_LEN=4, REG_WIDTH=8). A queue-based reference model
// tracks the drain phase, FIFO contents and counters; each test records per-cycle
// DUT outputs and model expectations, then compares them inline.
// Build with VECSHIFT_DRAIN_TIMEOUT_EN defined to exercise the watchdog.
module tb_vecshift_drain;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
  localparam int SW = 6 + CW;
  localparam logic [1:0] C_IDLE = 2'b00;
  localparam logic [1:0] C_PAR  = 2'b01;
  localparam logic [1:0] C_DIS  = 2'b11;

  typedef enum int {MIdle, MArm, MShift, MFlush} mphase_e;

  logic          clk = 1'b0;
  logic          rst, start, busy, timeout_err;
  logic [1:0]    col_conf, col_status;
  logic [W-1:0]  col_data;
  logic [CW-1:0] word_count;

  vecshift_drain_if #(.REG_WIDTH(W)) out_if ();

  vecshift_drain #(.REG_WIDTH(W), .COL_LEN(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .colConfSig (col_conf),
    .colData    (col_data),
    .colStatus  (col_status),
    .out        (out_if),
    .wordCount  (word_count),
    .timeoutErr (timeout_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  mphase_e       m_phase;
  logic [1:0]    m_conf;
  logic [W:0]    m_q[$];
  logic [CW-1:0] m_wc;
  logic          m_to;
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
  int            m_wd;
`endif

  // Column stimulus: {isLast, isData, data}, one entry consumed per SHIFT cycle.
  logic [W+1:0]  col_q[$];
  logic [W:0]    want[$];

  logic [SW-1:0] obs_sig[$], exp_sig[$];
  logic [W-1:0]  obs_dat[$], exp_dat[$];
  logic [W:0]    obs_pop[$], exp_pop[$];

  task automatic clear_traces();
    obs_sig.delete(); exp_sig.delete();
    obs_dat.delete(); exp_dat.delete();
    obs_pop.delete(); exp_pop.delete();
  endtask

  function automatic logic rdy_of(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  // One clock: record outputs, drive inputs, advance the model to the next edge.
  task automatic tick(input logic st, input logic rdy, input logic r);
    logic [W+1:0] ent;
    logic         pop, push, full;
    mphase_e      nxt;
    @(negedge clk);
    obs_sig.push_back({busy, col_conf, out_if.outValid, out_if.outLast, word_count,
                       timeout_err});
    exp_sig.push_back({m_phase != MIdle, m_conf, m_q.size() != 0,
                       (m_q.size() != 0) && m_q[0][W], m_wc, m_to});
    obs_dat.push_back(out_if.outValid ? out_if.outData : '0);
    exp_dat.push_back(m_q.size() != 0 ? m_q[0][W-1:0] : '0);
    if (m_phase == MShift && col_q.size() != 0) ent = col_q.pop_front();
    else ent = {2'($urandom), W'($urandom)};
    rst = r; start = st; out_if.outReady = rdy;
    col_status = ent[W+1:W]; col_data = ent[W-1:0];
    if (out_if.outValid && rdy) obs_pop.push_back({out_if.outLast, out_if.outData});
    if (r) begin
      m_phase = MIdle; m_q.delete(); m_wc = '0; m_to = 1'b0; m_conf = C_DIS;
    end else begin
      pop  = (m_q.size() != 0) && rdy;
      push = (m_phase == MShift) && ent[W];
      full = (m_q.size() == N);
      nxt  = m_phase;
      case (m_phase)
        MIdle:  if (st && m_q.size() == 0) begin nxt = MArm; m_wc = '0; m_to = 1'b0; end
        MArm:   begin
          nxt = MShift;
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
          m_wd = 0;
`endif
        end
        MShift: begin
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
          m_wd++;
`endif
          if (push && ent[W+1]) nxt = MFlush;
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
          else if (m_wd == N + 2) begin nxt = MFlush; m_to = 1'b1; end
`endif
        end
        default: nxt = MIdle;
      endcase
      if (pop) exp_pop.push_back(m_q.pop_front());
      if (push && (!full || pop)) begin
        m_q.push_back({ent[W+1], ent[W-1:0]});
        if (m_wc < CW'(N)) m_wc++;
      end
      m_phase = nxt;
      m_conf  = (nxt == MArm) ? C_PAR : (nxt == MFlush) ? C_DIS : C_IDLE;
    end
    @(posedge clk);
  endtask

  task automatic run_col(input int mode);
    tick(1'b1, rdy_of(mode), 1'b0);
    for (int i = 0; i < 40 && m_phase != MIdle; i++) tick(1'b0, rdy_of(mode), 1'b0);
  endtask

  task automatic drain_out();
    for (int i = 0; i < N + 2 && m_q.size() != 0; i++) tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic load_words(input int n, input int gaps);
    logic [W-1:0] d;
    col_q.delete(); want.delete();
    for (int i = 0; i < n; i++) begin
      if (gaps != 0 && i != 0) col_q.push_back({2'b00, W'($urandom)});
      d = W'($urandom);
      col_q.push_back({(i == n - 1), 1'b1, d});
      want.push_back({(i == n - 1), d});
    end
  endtask

  task automatic test_reset();
    clear_traces();
    tick(1'b0, 1'b0, 1'b1);
    #1;
    n_total++;
    if (col_conf !== C_DIS || out_if.outValid !== 1'b0 || out_if.outLast !== 1'b0 ||
        word_count !== '0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_vals got conf=%b v=%b l=%b wc=%0d to=%b busy=%b want conf=11 rest 0",
               col_conf, out_if.outValid, out_if.outLast, word_count, timeout_err, busy);
    end
    tick(1'b0, 1'b0, 1'b0);
    #1;
    n_total++;
    if (col_conf !== C_IDLE) begin
      n_bad++;
      $display("FAIL reset_release_conf got %b want %b", col_conf, C_IDLE);
    end
    tick(1'b0, 1'b0, 1'b0);
    foreach (obs_sig[i]) begin
      n_total++;
      if (obs_sig[i] !== exp_sig[i] || obs_dat[i] !== exp_dat[i]) begin
        n_bad++;
        $display("FAIL reset_trace cyc=%0d got sig=%b dat=%h want sig=%b dat=%h",
                 i, obs_sig[i], obs_dat[i], exp_sig[i], exp_dat[i]);
      end
    end
  endtask

  task automatic check_pops(input string name);
    n_total++;
    if (obs_pop.size() != want.size()) begin
      n_bad++;
      $display("FAIL %s_count got %0d want %0d", name, obs_pop.size(), want.size());
    end
    foreach (want[i]) begin
      if (i < obs_pop.size()) begin
        n_total++;
        if (obs_pop[i] !== want[i]) begin
          n_bad++;
          $display("FAIL %s_word%0d got %h want %h", name, i, obs_pop[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_drain_basic();
    int n_par, n_dis;
    clear_traces();
    load_words(4, 0);
    run_col(1);
    drain_out();
    #1;
    n_total++;
    if (word_count !== CW'(4) || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_end got wc=%0d busy=%b want wc=4 busy=0", word_count, busy);
    end
    n_par = 0; n_dis = 0;
    foreach (obs_sig[i]) begin
      if (obs_sig[i][SW-2:SW-3] == C_PAR) n_par++;
      if (obs_sig[i][SW-2:SW-3] == C_DIS) n_dis++;
      n_total++;
      if (obs_sig[i] !== exp_sig[i] || obs_dat[i] !== exp_dat[i]) begin
        n_bad++;
        $display("FAIL basic_trace cyc=%0d got sig=%b dat=%h want sig=%b dat=%h",
                 i, obs_sig[i], obs_dat[i], exp_sig[i], exp_dat[i]);
      end
    end
    n_total++;
    if (n_par != 1 || n_dis != 1) begin
      n_bad++;
      $display("FAIL basic_conf_cycles got par=%0d dis=%0d want 1 and 1", n_par, n_dis);
    end
    check_pops("basic");
  endtask

  task automatic test_backpressure();
    clear_traces();
    load_words(4, 0);
    run_col(0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    #1;
    n_total++;
    if (busy !== 1'b0 || out_if.outValid !== 1'b1 || col_conf !== C_IDLE) begin
      n_bad++;
      $display("FAIL bp_start_ignored got busy=%b valid=%b conf=%b want 0 1 00",
               busy, out_if.outValid, col_conf);
    end
    for (int i = 0; i < N + 1; i++) tick(1'b0, 1'b1, 1'b0);
    foreach (obs_sig[i]) begin
      n_total++;
      if (obs_sig[i] !== exp_sig[i] || obs_dat[i] !== exp_dat[i]) begin
        n_bad++;
        $display("FAIL bp_trace cyc=%0d got sig=%b dat=%h want sig=%b dat=%h",
                 i, obs_sig[i], obs_dat[i], exp_sig[i], exp_dat[i]);
      end
    end
    check_pops("bp");
  endtask

  task automatic test_gaps();
    clear_traces();
    load_words(3, 1);
    run_col(1);
    drain_out();
    #1;
    n_total++;
    if (word_count !== CW'(3)) begin
      n_bad++;
      $display("FAIL gaps_wc got %0d want 3", word_count);
    end
    foreach (obs_sig[i]) begin
      n_total++;
      if (obs_sig[i] !== exp_sig[i] || obs_dat[i] !== exp_dat[i]) begin
        n_bad++;
        $display("FAIL gaps_trace cyc=%0d got sig=%b dat=%h want sig=%b dat=%h",
                 i, obs_sig[i], obs_dat[i], exp_sig[i], exp_dat[i]);
      end
    end
    check_pops("gaps");
  endtask

  task automatic test_reset_mid();
    clear_traces();
    load_words(4, 0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && m_q.size() < 2; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    col_q.delete();
    #1;
    n_total++;
    if (out_if.outValid !== 1'b0 || word_count !== '0 || col_conf !== C_DIS) begin
      n_bad++;
      $display("FAIL midrst_vals got valid=%b wc=%0d conf=%b want 0 0 11",
               out_if.outValid, word_count, col_conf);
    end
    tick(1'b0, 1'b0, 1'b0);
    load_words(2, 0);
    run_col(1);
    drain_out();
    foreach (obs_sig[i]) begin
      n_total++;
      if (obs_sig[i] !== exp_sig[i] || obs_dat[i] !== exp_dat[i]) begin
        n_bad++;
        $display("FAIL midrst_trace cyc=%0d got sig=%b dat=%h want sig=%b dat=%h",
                 i, obs_sig[i], obs_dat[i], exp_sig[i], exp_dat[i]);
      end
    end
    check_pops("midrst");
  endtask

`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
  task automatic test_timeout();
    clear_traces();
    col_q.delete();
    for (int i = 0; i < 8; i++) col_q.push_back({2'b01, W'($urandom)});
    run_col(0);
    #1;
    n_total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || word_count !== CW'(N)) begin
      n_bad++;
      $display("FAIL timeout_set got to=%b busy=%b wc=%0d want 1 0 %0d",
               timeout_err, busy, word_count, N);
    end
    col_q.delete();
    drain_out();
    load_words(1, 0);
    tick(1'b1, 1'b1, 1'b0);
    #1;
    n_total++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_clear got %b want 0", timeout_err);
    end
    for (int i = 0; i < 10 && m_phase != MIdle; i++) tick(1'b0, 1'b1, 1'b0);
    drain_out();
    foreach (obs_sig[i]) begin
      n_total++;
      if (obs_sig[i] !== exp_sig[i] || obs_dat[i] !== exp_dat[i]) begin
        n_bad++;
        $display("FAIL timeout_trace cyc=%0d got sig=%b dat=%h want sig=%b dat=%h",
                 i, obs_sig[i], obs_dat[i], exp_sig[i], exp_dat[i]);
      end
    end
  endtask
`else
  task automatic test_no_timeout();
    clear_traces();
    col_q.delete();
    for (int i = 0; i < 12; i++) col_q.push_back({2'b01, W'($urandom)});
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b1, 1'b0);
    #1;
    n_total++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL no_timeout got busy=%b to=%b want 1 0", busy, timeout_err);
    end
    tick(1'b0, 1'b1, 1'b1);
    col_q.delete();
    tick(1'b0, 1'b0, 1'b0);
    foreach (obs_sig[i]) begin
      n_total++;
      if (obs_sig[i] !== exp_sig[i] || obs_dat[i] !== exp_dat[i]) begin
        n_bad++;
        $display("FAIL notimeout_trace cyc=%0d got sig=%b dat=%h want sig=%b dat=%h",
                 i, obs_sig[i], obs_dat[i], exp_sig[i], exp_dat[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int len;
    clear_traces();
    for (int it = 0; it < 25; it++) begin
      col_q.delete();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if (i == len - 1) col_q.push_back({2'b11, W'($urandom)});
        else col_q.push_back({1'b0, ($urandom_range(0, 3) != 0), W'($urandom)});
      end
      run_col(2);
      if ($urandom_range(0, 1) == 1) tick(1'b1, 1'b0, 1'b0);
      drain_out();
      col_q.delete();
      tick(1'b0, 1'b0, 1'b0);
    end
    foreach (obs_sig[i]) begin
      n_total++;
      if (obs_sig[i] !== exp_sig[i] || obs_dat[i] !== exp_dat[i]) begin
        n_bad++;
        $display("FAIL random_trace cyc=%0d got sig=%b dat=%h want sig=%b dat=%h",
                 i, obs_sig[i], obs_dat[i], exp_sig[i], exp_dat[i]);
      end
    end
    n_total++;
    if (obs_pop.size() != exp_pop.size()) begin
      n_bad++;
      $display("FAIL random_pop_count got %0d want %0d", obs_pop.size(), exp_pop.size());
    end
    foreach (exp_pop[i]) begin
      if (i < obs_pop.size()) begin
        n_total++;
        if (obs_pop[i] !== exp_pop[i]) begin
          n_bad++;
          $display("FAIL random_pop%0d got %h want %h", i, obs_pop[i], exp_pop[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_if.outReady = 1'b0;
    col_status = 2'b00; col_data = '0;
    m_phase = MIdle; m_conf = C_DIS; m_wc = '0; m_to = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_drain_basic();
    test_backpressure();
    test_gaps();
    test_reset_mid();
`ifdef VECSHIFT_DRAIN_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit reached without finishing");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/vecshift_drain.md
VECSHIFT_DRAIN -- requirements
Module: vecshift_drain

Interface
REQ-001 Parameter REG_WIDTH, default -1, SHALL set the column word width; elaboration SHALL fail unless REG_WIDTH > 0.
REQ-002 Parameter COL_LEN, default 8, SHALL set the number of vecshift registers in the column and the FIFO depth; elaboration SHALL fail unless COL_LEN >= 2.
REQ-003 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  level request to drain the column.
REQ-007 busy  output  1  high whenever the state is not IDLE.
REQ-008 colConfSig  output  VECREG_CONFIG_WIDTH  confSig broadcast to all column registers, using the VECREG_* encodings of vecshift_reg.svh.
REQ-009 colData  input  REG_WIDTH  parallelOut of the column's output-end register.
REQ-010 colStatus  input  VECREG_STATUS_WIDTH  statusOut of the column's output-end register, packed {isLast, isData}.
REQ-011 outData  output  REG_WIDTH  FIFO head word.
REQ-012 outValid  output  1  FIFO non-empty.
REQ-013 outReady  input  1  consumer accepts outData.
REQ-014 outLast  output  1  head word carried isLast.
REQ-015 wordCount  output  $clog2(COL_LEN+1)  words captured in the current or most recent drain.
REQ-016 timeoutErr  output  1  sticky watchdog error flag.

Function
REQ-017 The FSM SHALL have four states: IDLE, ARM, SHIFT and FLUSH; colConfSig SHALL be registered.
REQ-018 In IDLE with start=1 and the FIFO empty, the FSM SHALL move to ARM, clear wordCount and clear timeoutErr; in IDLE, start SHALL be ignored while the FIFO is non-empty, and in any other state start SHALL be ignored.
REQ-019 colConfSig SHALL be VECREG_PARALLEL_EN for exactly the ARM cycle, VECREG_DISABLE for exactly the FLUSH cycle, and VECREG_IDLE otherwise.
REQ-020 ARM SHALL last one cycle and then go to SHIFT.
REQ-021 In SHIFT, each cycle with colStatus[0]=1 SHALL push {colStatus[1], colData} into the FIFO and increment wordCount.
REQ-022 In SHIFT, cycles with colStatus[0]=0 SHALL push nothing.
REQ-023 A push carrying colStatus[1]=1 SHALL move the FSM to FLUSH in the same edge.
REQ-024 FLUSH SHALL last one cycle and then go to IDLE.
REQ-025 The FIFO SHALL be first-word-fall-through with COL_LEN entries of REG_WIDTH+1 bits.
REQ-026 A pop SHALL occur when outValid && outReady.
REQ-027 When a push and a pop occur in the same cycle on a full FIFO, both SHALL occur.
REQ-028 A push into a full FIFO without a simultaneous pop SHALL be dropped, and wordCount SHALL NOT increment for it.
REQ-029 On an empty FIFO, a push SHALL make outValid high on the next cycle.
REQ-030 Words SHALL emerge in capture order.
REQ-031 wordCount SHALL saturate at COL_LEN.

Reset
REQ-032 While rst=1 the block SHALL, at each edge, set: state=IDLE, FIFO empty, outValid=0, outLast=0, wordCount=0, timeoutErr=0, colConfSig=VECREG_DISABLE.
REQ-033 On the first edge after rst falls, the block SHALL set colConfSig to VECREG_IDLE.
REQ-034 Reset asserted mid-drain SHALL discard all FIFO contents and all captured words.
REQ-035 outData SHALL be don't-care while outValid=0.

Configuration
REQ-036 With macro VECSHIFT_DRAIN_TIMEOUT_EN defined, a watchdog SHALL count SHIFT cycles.
REQ-037 When the watchdog count reaches COL_LEN+2 without an isLast push, the block SHALL set timeoutErr=1 and go to FLUSH; timeoutErr SHALL remain set until the next accepted start or rst.
REQ-038 Without VECSHIFT_DRAIN_TIMEOUT_EN, the watchdog logic SHALL be absent, timeoutErr SHALL be tied to 0, and SHIFT SHALL be left only on an isLast push or rst.

Verification
REQ-039 Scenario 1: COL_LEN=4, outReady=1, column words A,B,C,D with isLast on D, start pulse -> colConfSig sequence IDLE,PARALLEL_EN,IDLE...,DISABLE,IDLE; outData A,B,C,D; outLast only on D; wordCount=4; busy drops after FLUSH.
REQ-040 Scenario 2: same stimulus with outReady=0 throughout -> FIFO holds 4 words and outValid=1; raising outReady drains A..D one per cycle; start asserted while the FIFO is non-empty -> no ARM.
REQ-041 Scenario 3: colStatus isData gaps (isData=0 on alternate cycles) -> only isData cycles are captured; order and count are preserved.
REQ-042 Scenario 4: rst asserted in SHIFT after 2 captures -> next cycle outValid=0, wordCount=0, colConfSig=DISABLE; a new start after reset drains correctly.
REQ-043 Scenario 5 (VECSHIFT_DRAIN_TIMEOUT_EN defined): isLast never asserted -> after 6 SHIFT cycles (COL_LEN=4) timeoutErr=1 and colConfSig=DISABLE for one cycle; the next accepted start clears timeoutErr.
